// File: rtl/dp_blockram_pkg.sv
// Shared constants for the dual-port block RAM: default scratchpad geometry and clear FSM states.
package dp_blockram_pkg;

   // Default scratchpad configuration: 8-bit words, 1024 entries.
   localparam int unsigned BR_DEF_WIDTH = 8;
   localparam int unsigned BR_DEF_DEPTH = 10;

   // Clear sequencer states.
   localparam logic BR_READY = 1'b0;
   localparam logic BR_CLEAR = 1'b1;

endpackage

// File: rtl/dp_blockram_if.sv
// One RAM access port: request (en/we/ad/din) from the master, read return (dout/rvalid) from the RAM.
interface dp_blockram_if
   import dp_blockram_pkg::*;
#(
   parameter int unsigned WIDTH = BR_DEF_WIDTH,
   parameter int unsigned DEPTH = BR_DEF_DEPTH
) ();

   logic             en;
   logic             we;
   logic [DEPTH-1:0] ad;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             rvalid;

   modport master (output en, we, ad, din, input dout, rvalid);
   modport slave  (input en, we, ad, din, output dout, rvalid);

endinterface

// File: rtl/dp_blockram_rdpipe.sv
// Per-port read return path: rvalid tracking, optional extra output register and parity check.
// dout holds the last returned word until another read completes.
module dp_blockram_rdpipe #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MW      = 8,
   parameter bit          OUT_REG = 1'b0,
   parameter bit          PARITY  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fire,
   input  logic [MW-1:0]    word,
   output logic [WIDTH-1:0] dout,
   output logic             rvalid,
   output logic             par_err
);

   logic             last_fire;
   logic [MW-1:0]    last_word;
   logic [WIDTH-1:0] dout_q;
   logic             rvalid_q;
   logic             perr_q;

   if (OUT_REG) begin : g_oreg
      logic          v1_q;
      logic [MW-1:0] w1_q;

      // Extra pipeline stage between array and output register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v1_q <= 1'b0;
            w1_q <= '0;
         end else begin
            v1_q <= fire;
            if (fire) w1_q <= word;
         end
      end

      assign last_fire = v1_q;
      assign last_word = w1_q;
   end else begin : g_noreg
      assign last_fire = fire;
      assign last_word = word;
   end

   // Output register: capture data on completion, pulse rvalid, flag odd parity on the stored word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q   <= '0;
         rvalid_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         rvalid_q <= last_fire;
         perr_q   <= last_fire & PARITY & (^last_word);
         if (last_fire) dout_q <= last_word[WIDTH-1:0];
      end
   end

   assign dout    = dout_q;
   assign rvalid  = rvalid_q;
   assign par_err = perr_q;

endmodule

// File: rtl/dp_blockram.sv
// Dual-port block RAM with collision flag and hardware clear sequencer.
// Optional feature: define DP_BLOCKRAM_PARITY_EN to store an even-parity bit per word and report
// parity errors on read returns; otherwise par_err stays 2'b00.
// INIT_FILE is carried for interface compatibility; array contents are undefined until written
// or cleared.
module dp_blockram
   import dp_blockram_pkg::*;
#(
   parameter int unsigned WIDTH     = BR_DEF_WIDTH,
   parameter int unsigned DEPTH     = BR_DEF_DEPTH,
   parameter bit          OUT_REG   = 1'b0,
   parameter bit          WR_FIRST  = 1'b0,
   parameter string       INIT_FILE = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          busy,
   dp_blockram_if.slave  a,
   dp_blockram_if.slave  b,
   output logic          coll,
   output logic [1:0]    par_err
);

`ifdef DP_BLOCKRAM_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif
   localparam int unsigned MW    = WIDTH + (PARITY ? 1 : 0);
   localparam int unsigned WORDS = 2 ** DEPTH;

   // Stored word: data plus parity bit when enabled (parity of all-zero data is 0).
   function automatic logic [MW-1:0] enc(input logic [WIDTH-1:0] d);
      logic [WIDTH:0] t;
      t = {^d, d};
      return t[MW-1:0];
   endfunction

   logic [MW-1:0]    mem [WORDS];
   logic             state_q;
   logic [DEPTH-1:0] ptr_q;
   logic             coll_q;
   logic             ready;
   logic             wr_a, wr_b;
   logic [MW-1:0]    rd_word_a, rd_word_b;
   logic             pe_a, pe_b;

   assign ready = (state_q == BR_READY);
   assign wr_a  = a.en & a.we & ready;
   assign wr_b  = b.en & b.we & ready;

   // Same-port write returns din only in write-first mode; cross-port reads always see old data.
   assign rd_word_a = (WR_FIRST && a.we) ? enc(a.din) : mem[a.ad];
   assign rd_word_b = (WR_FIRST && b.we) ? enc(b.din) : mem[b.ad];

   // Array update: the clear sequencer owns the array while busy; port A is written last so it
   // wins a same-address write/write. Reset never touches the contents.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == BR_CLEAR) begin
            mem[ptr_q] <= enc('0);
         end else begin
            if (wr_b) mem[b.ad] <= enc(b.din);
            if (wr_a) mem[a.ad] <= enc(a.din);
         end
      end
   end

   // Clear FSM and collision flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BR_READY;
         ptr_q   <= '0;
         coll_q  <= 1'b0;
      end else begin
         coll_q <= wr_a & wr_b & (a.ad == b.ad);
         if (state_q == BR_READY) begin
            if (clr) begin
               state_q <= BR_CLEAR;
               ptr_q   <= '0;
            end
         end else begin
            ptr_q <= ptr_q + DEPTH'(1);
            if (&ptr_q) state_q <= BR_READY;
         end
      end
   end

   assign busy = (state_q == BR_CLEAR);
   assign coll = coll_q;

   dp_blockram_rdpipe #(
      .WIDTH   (WIDTH),
      .MW      (MW),
      .OUT_REG (OUT_REG),
      .PARITY  (PARITY)
   ) u_rd_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .fire    (a.en & ready),
      .word    (rd_word_a),
      .dout    (a.dout),
      .rvalid  (a.rvalid),
      .par_err (pe_a)
   );

   dp_blockram_rdpipe #(
      .WIDTH   (WIDTH),
      .MW      (MW),
      .OUT_REG (OUT_REG),
      .PARITY  (PARITY)
   ) u_rd_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .fire    (b.en & ready),
      .word    (rd_word_b),
      .dout    (b.dout),
      .rvalid  (b.rvalid),
      .par_err (pe_b)
   );

   assign par_err = {pe_b, pe_a};

endmodule
